// File: rtl/baud_timing_gen.sv
// baud_timing_gen: programmable, oversampling baud timing generator.
// Produces SampleTick at OVERSAMPLE x baud, BaudTick once per bit and a
// 50%-duty baud-rate Clk from a fractional (integer + 2^-FRAC_WIDTH) divisor
// that can be reloaded at runtime. New divisors only take effect on a bit
// boundary while running, so a bit period is never split between two rates.
module baud_timing_gen #(
    parameter int SYSCLK_RATE = 100000000,
    parameter int BAUD_RATE   = 9600,
    parameter int OVERSAMPLE  = 16,
    parameter int DIV_WIDTH   = 16,
    parameter int FRAC_WIDTH  = 4
) (
    input  logic                  SysClk,
    input  logic                  Rst,
    input  logic                  En,
    input  logic [DIV_WIDTH-1:0]  DivInt,
    input  logic [FRAC_WIDTH-1:0] DivFrac,
    input  logic                  DivLoad,
    output logic                  SampleTick,
    output logic                  BaudTick,
    output logic                  Clk,
    output logic                  CfgErr
);

    // One extra counter bit so DivInt+1 fits even at the maximum DivInt.
    localparam int CNT_W = DIV_WIDTH + 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);

    // Power-up divisor in 2^-FRAC_WIDTH units, split into integer/fraction.
    localparam longint unsigned RST_DIV =
        (longint'(SYSCLK_RATE) << FRAC_WIDTH) / (longint'(BAUD_RATE) * longint'(OVERSAMPLE));
    localparam logic [DIV_WIDTH-1:0]  RST_INT  = DIV_WIDTH'(RST_DIV >> FRAC_WIDTH);
    localparam logic [FRAC_WIDTH-1:0] RST_FRAC = FRAC_WIDTH'(RST_DIV);

    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [DIV_WIDTH-1:0]  shadow_int, active_int;
    logic [FRAC_WIDTH-1:0] shadow_frac, active_frac;
    logic                  pending;
    logic [CNT_W-1:0]      period_cnt;
    logic [FRAC_WIDTH-1:0] acc;
    logic [OS_W-1:0]       os_cnt;

    logic                  load_ok;
    logic                  period_end;
    logic                  os_wrap;
    logic                  copy_now;
    logic                  carry;
    logic [FRAC_WIDTH-1:0] acc_sum;
    logic [OS_W-1:0]       os_next;
    logic [CNT_W-1:0]      reload_cur;
    logic [CNT_W-1:0]      reload_new;

    // Next-state logic and the per-period arithmetic shared by the datapath.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d    = state_q;
        period_end = 1'b0;
        load_ok    = DivLoad && (DivInt >= DIV_WIDTH'(2));
        {carry, acc_sum} = {1'b0, acc} + {1'b0, active_frac};

        unique case (state_q)
            IDLE: begin
                if (En) state_d = RUN;
            end
            RUN: begin
                if (!En) state_d = IDLE;
                period_end = (period_cnt == '0);
            end
            default: state_d = IDLE;
        endcase

        os_wrap    = period_end && (os_cnt == OS_LAST);
        os_next    = os_wrap ? '0 : os_cnt + OS_W'(1);
        copy_now   = os_wrap && pending;
        // Carry out of the accumulator stretches the next period by one cycle.
        reload_cur = {1'b0, active_int} + CNT_W'(carry) - CNT_W'(1);
        // A freshly copied divisor starts with an integer-only period.
        reload_new = {1'b0, shadow_int} - CNT_W'(1);
    end

    // State register.
    always_ff @(posedge SysClk or negedge Rst) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
        if (!Rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Shadow/active divisor registers, pending-update flag and sticky config error.
    always_ff @(posedge SysClk or negedge Rst) begin
        if (!Rst) begin
            // NOTE: the divisor resets to the computed default rate, not to zero, so En alone starts a usable baud.
            shadow_int  <= RST_INT;
            shadow_frac <= RST_FRAC;
            active_int  <= RST_INT;
            active_frac <= RST_FRAC;
            pending     <= 1'b0;
            CfgErr      <= 1'b0;
        end else begin
            if (DivLoad) begin
                CfgErr <= ~load_ok;
                if (load_ok) begin
                    shadow_int  <= DivInt;
                    shadow_frac <= DivFrac;
                end
            end
            if (state_q == IDLE || copy_now) begin
                active_int  <= shadow_int;
                active_frac <= shadow_frac;
            end
            if (load_ok)                          pending <= 1'b1;
            else if (state_q == IDLE || copy_now) pending <= 1'b0;
        end
    end

    // Period counter, fractional accumulator, oversample counter and registered outputs.
    always_ff @(posedge SysClk or negedge Rst) begin
        if (!Rst) begin
            period_cnt <= '0;
            acc        <= '0;
            os_cnt     <= '0;
            SampleTick <= 1'b0;
            BaudTick   <= 1'b0;
            Clk        <= 1'b0;
        end else if (state_d == IDLE) begin
            period_cnt <= '0;
            acc        <= '0;
            os_cnt     <= '0;
            SampleTick <= 1'b0;
            BaudTick   <= 1'b0;
            Clk        <= 1'b0;
        end else if (state_q == IDLE) begin
            period_cnt <= reload_new;
            acc        <= '0;
            os_cnt     <= '0;
            SampleTick <= 1'b0;
            BaudTick   <= 1'b0;
            Clk        <= 1'b0;
        end else if (period_end) begin
            SampleTick <= 1'b1;
            BaudTick   <= os_wrap;
            os_cnt     <= os_next;
            if (os_wrap)                 Clk <= 1'b1;
            else if (os_next == OS_HALF) Clk <= 1'b0;
            if (copy_now) begin
                period_cnt <= reload_new;
                acc        <= '0;
            end else begin
                period_cnt <= reload_cur;
                acc        <= acc_sum;
            end
        end else begin
            SampleTick <= 1'b0;
            BaudTick   <= 1'b0;
            period_cnt <= period_cnt - CNT_W'(1);
        end
    end

endmodule

// File: doc/baud_timing_gen.md
Name: baud_timing_gen

Overview:
- Programmable, oversampling baud timing generator; successor to the fixed-divide UART clock generator.
- Produces a one-cycle SampleTick at OVERSAMPLE x baud, a one-cycle BaudTick once per bit time, and a 50%-duty Clk at baud rate.
- Divisor has integer and fractional parts and is runtime-reloadable, so UART TX/RX change baud without resynthesis.
- Sits between the system clock and the UART transmitter/receiver datapaths.

Parameters:
- SYSCLK_RATE, 100000000: SysClk frequency in Hz.
- BAUD_RATE, 9600: baud rate used to compute the reset divisor.
- OVERSAMPLE, 16: SampleTicks per bit. Even, >=4.
- DIV_WIDTH, 16: integer divisor width.
- FRAC_WIDTH, 4: fractional divisor width.

Ports:
- SysClk  in  1  system clock; all logic on its rising edge.
- Rst  in  1  asynchronous, active-low reset.
- En  in  1  run enable; low forces IDLE.
- DivInt  in  DIV_WIDTH  integer SysClk cycles per SampleTick.
- DivFrac  in  FRAC_WIDTH  fractional part, in units of 2^-FRAC_WIDTH.
- DivLoad  in  1  one-cycle strobe that captures DivInt/DivFrac.
- SampleTick  out  1  one-cycle pulse per oversample period.
- BaudTick  out  1  one-cycle pulse per bit period.
- Clk  out  1  baud-rate square wave.
- CfgErr  out  1  sticky flag set when a load is rejected.

Behaviour:
- Reset (Rst=0, async): all outputs 0; state IDLE; counters and accumulator 0.
- Reset divisor is loaded into both shadow and active registers:
  - D = floor((SYSCLK_RATE << FRAC_WIDTH) / (BAUD_RATE*OVERSAMPLE)).
  - Integer part = D >> FRAC_WIDTH; fractional part = low FRAC_WIDTH bits.
  - Defaults give 651 / 0.
- State IDLE:
  - All outputs except CfgErr are held at 0; counters and accumulator are held at 0.
  - En=1 moves to RUN on the next edge. Period counter loads active period-1; first period uses the integer part only.
- State RUN, fractional period generation:
  - Each period is DivInt or DivInt+1 SysClk cycles.
  - At each period end, acc <= acc + DivFrac (FRAC_WIDTH bits, wraps).
  - Carry out of that add makes the next period DivInt+1; no carry makes it DivInt.
  - Long-run average period = DivInt + DivFrac/2^FRAC_WIDTH.
- State RUN, ticks:
  - SampleTick is registered and high for exactly one cycle at each period end.
  - The first SampleTick is on the DivInt-th rising edge after entering RUN.
  - Oversample counter counts 0..OVERSAMPLE-1 on SampleTick and wraps to 0.
  - BaudTick is high in the same cycle as the SampleTick that wraps the counter.
- Clk:
  - Toggles 1 -> 0 on the SampleTick that brings the counter to OVERSAMPLE/2.
  - Toggles 0 -> 1 on the wrapping SampleTick.
  - Effect: Clk rises with BaudTick and has 50% duty counted in SampleTicks.
- DivLoad (RUN or IDLE):
  - DivInt >= 2: captured into the shadow register and CfgErr is cleared.
  - DivInt < 2: rejected, shadow unchanged, CfgErr set.
  - In RUN, shadow is copied to active only at a BaudTick, so bit periods are never split; the accumulator clears on that copy.
  - In IDLE, shadow is copied to active on the next edge.
  - Several loads before a BaudTick: the last valid one wins.
  - DivLoad in the same cycle as BaudTick: the new value takes effect at the following BaudTick.
- En deasserted mid-bit: return to IDLE on the next edge; outputs drop to 0 and counters clear (no partial tick, no pending update lost).
- Rst mid-operation: immediate return to reset values, including the shadow divisor and CfgErr=0.
- Arithmetic: counters are DIV_WIDTH+1 bits, so DivInt+1 never overflows, including DivInt = 2^DIV_WIDTH-1.
- Latency: DivLoad to new rate is at most one bit period plus one cycle.

Test Plan:
- Reset values: hold Rst=0, then release with En=0 -> all outputs 0, no ticks for 1000 cycles. Raise En with defaults -> SampleTick spacing 651, BaudTick spacing 10416.
- Integer divisor: DivLoad DivInt=4, DivFrac=0, OVERSAMPLE=16, then En=1 -> SampleTick every 4 cycles, BaudTick every 64 cycles, Clk high 32 / low 32.
- Fractional divisor: DivInt=4, DivFrac=8, FRAC_WIDTH=4 -> sample periods alternate 4,5; exactly 16 SampleTicks in 72 cycles; BaudTick spacing 72.
- Reload mid-bit: running DivInt=4, then load DivInt=8 at sample 5 -> spacing stays 4 until the next BaudTick, then 8; no BaudTick is ever spaced other than 64 or 128.
- Invalid load: DivLoad DivInt=1 -> CfgErr=1 and rate unchanged. A following load of DivInt=3 -> CfgErr=0 and the new rate applies.
- Disable and reset mid-operation: drop En mid-bit -> outputs 0 next cycle; on re-enable the first SampleTick comes after DivInt cycles. Assert Rst mid-run -> async clear and divisor returns to 651/0.
